// File: rtl/program_loader.sv
// Byte-stream program loader: length byte, little-endian words, one write strobe per word.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int width = 32,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_clr,
    output logic             mem_write,
    output logic [width-1:0] mem_data,
    output logic [7:0]       word_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int BYTES = width / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t state, state_nx;

    logic [7:0]       n_words;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             start_ok;
    logic             len_bad;
    logic             last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept    = byte_valid && byte_ready;
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
    assign len_bad   = (byte_data == 8'd0) || ({24'd0, byte_data} > 32'(DEPTH));
    assign last_word = (word_count + 8'd1) == n_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        mem_write  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: if (start) state_nx = LEN;
            LEN: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_nx = len_bad ? ERR : DATA;
            end
            DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && idx == LAST_IDX) state_nx = WRITE;
            end
            WRITE: begin
                mem_write = 1'b1;
                busy      = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_nx  = last_word ? CSUM : DATA;
`else
                state_nx  = last_word ? DONE : DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_nx = (byte_data == csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_nx = LEN;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nx = LEN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Word assembly, counters and the memory-clear pulse; reset never raises mem_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_clr    <= 1'b0;
            mem_data   <= '0;
            word_count <= 8'd0;
            n_words    <= 8'd0;
            idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            mem_clr <= 1'b0;
            if (start_ok) begin
                mem_clr    <= 1'b1;
                word_count <= 8'd0;
                idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum       <= 8'd0;
`endif
            end
            if (state == LEN && accept) n_words <= byte_data;
            if (state == DATA && accept) begin
                mem_data[{idx, 3'b000} +: 8] <= byte_data;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ byte_data;
`endif
            end
            if (state == WRITE) word_count <= word_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: cycle-by-cycle vector table plus multi-cycle sequences.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_clr, mem_write, busy, done, error;
    logic [31:0] mem_data;
    logic [7:0]  word_count;

    program_loader #(.width(32), .DEPTH(128)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_clr(mem_clr),
        .mem_write(mem_write), .mem_data(mem_data), .word_count(word_count),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy, clr, wr, bsy, dn, err;
        logic [7:0]  wc;
        logic [31:0] data;
    } out_t;

    typedef struct {
        logic       st;
        logic       bv;
        logic [7:0] bd;
        out_t       exp;
    } vec_t;

    vec_t        vecs[$];
    int          total = 0;
    int          passed = 0;
    int          wr_cnt = 0;
    int          clr_cnt = 0;
    logic [31:0] last_data = '0;

    always @(posedge clk) begin
        if (mem_write) begin
            wr_cnt    <= wr_cnt + 1;
            last_data <= mem_data;
        end
        if (mem_clr) clr_cnt <= clr_cnt + 1;
    end

    function automatic out_t cur();
        out_t o;
        o = {byte_ready, mem_clr, mem_write, busy, done, error, word_count, mem_data};
        return o;
    endfunction

    function automatic vec_t mk(logic st, logic bv, logic [7:0] bd, logic r, logic c, logic w,
                                logic b, logic d, logic e, logic [7:0] wc, logic [31:0] data);
        vec_t v;
        v.st  = st;
        v.bv  = bv;
        v.bd  = bd;
        v.exp = {r, c, w, b, d, e, wc, data};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            total++;
            $display("FAIL send_byte: byte_ready stayed 0 for byte %0h, expected 1", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            $display("FAIL wait_not_busy: busy got 1, expected 0");
        end
    endtask

    initial begin
        int          wr0, clr0;
        logic [7:0]  s[$];

        // One row per cycle: inputs for the cycle and outputs expected during it.
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 8'h02, 1, 1, 0, 1, 0, 0, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 8'h13, 1, 0, 0, 1, 0, 0, 8'd0, 32'h0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 8'd0, 32'h13));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 8'd0, 32'h13));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 8'd0, 32'h13));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'd0, 32'h13));
        vecs.push_back(mk(0, 1, 8'h93, 1, 0, 0, 1, 0, 0, 8'd1, 32'h13));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 8'd1, 32'h93));
        vecs.push_back(mk(0, 1, 8'h10, 1, 0, 0, 1, 0, 0, 8'd1, 32'h93));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 8'd1, 32'h00100093));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'd1, 32'h00100093));
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back(mk(0, 1, 8'h90, 1, 0, 0, 1, 0, 0, 8'd2, 32'h00100093));
`endif
        vecs.push_back(mk(0, 1, 8'h55, 0, 0, 0, 0, 1, 0, 8'd2, 32'h00100093));
        vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 0, 1, 0, 8'd2, 32'h00100093));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'd2, 32'h00100093));

        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_state", 64'(cur()), 64'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(cur()), 64'(vecs[i].exp));
            start      = vecs[i].st;
            byte_valid = vecs[i].bv;
            byte_data  = vecs[i].bd;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        check("table_wr_count", 64'(wr_cnt), 64'd2);
        check("table_clr_count", 64'(clr_cnt), 64'd1);

        // Zero length, then a length one past DEPTH.
        wr0 = wr_cnt;
        pulse_start();
        check("restart_from_done", 64'({mem_clr, done, busy, word_count}), 64'({1'b1, 1'b0, 1'b1, 8'd0}));
        send_byte(8'h00);
        wait_not_busy();
        check("len0_err", 64'({error, done}), 64'b10);
        pulse_start();
        check("restart_from_err", 64'({mem_clr, error, busy}), 64'b101);
        send_byte(8'h81);
        wait_not_busy();
        check("len81_err", 64'({error, done}), 64'b10);
        check("len_err_no_write", 64'(wr_cnt - wr0), 64'd0);
        pulse_start();
        send_byte(8'h80);
        check("len80_accepted", 64'({busy, byte_ready, error}), 64'b110);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        wr0 = wr_cnt;
        pulse_start();
        s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        foreach (s[k]) send_byte(s[k]);
        wait_not_busy();
        check("csum_bad", 64'({error, done}), 64'b10);
        check("csum_bad_writes", 64'(wr_cnt - wr0), 64'd2);
`endif

        // N=1 with a mid-word gap and a start while busy.
        wr0  = wr_cnt;
        clr0 = clr_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("gap_hold", 64'({busy, byte_ready, mem_write, word_count}), 64'({3'b110, 8'd0}));
        send_byte(8'hCC);
        send_byte(8'hDD);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_not_busy();
        check("gap_writes", 64'(wr_cnt - wr0), 64'd1);
        check("gap_word", 64'(last_data), 64'hDDCCBBAA);
        check("gap_clr_once", 64'(clr_cnt - clr0), 64'd1);
        check("gap_done", 64'({done, error, word_count}), 64'({2'b10, 8'd1}));

        // N=3 with asynchronous reset after the first word.
        wr0 = wr_cnt;
        pulse_start();
        s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (s[k]) send_byte(s[k]);
        @(negedge clk);
        check("pre_rst_word1", 64'({word_count, 8'(wr_cnt - wr0)}), 64'({8'd1, 8'd1}));
        clr0 = clr_cnt;
        #2 rst = 1'b1;
        #1 check("async_rst_zero", 64'(cur()), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_data = 8'h55;
        repeat (3) @(negedge clk);
        check("idle_ignores_bytes", 64'({byte_ready, busy, done, error}), 64'h0);
        byte_valid = 1'b0;
        check("rst_no_more_writes", 64'(wr_cnt - wr0), 64'd1);
        check("rst_no_clr", 64'(clr_cnt - clr0), 64'd0);
        wr0 = wr_cnt;
        pulse_start();
        s = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (s[k]) send_byte(s[k]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h08);
`endif
        wait_not_busy();
        check("post_rst_session", 64'({done, error, word_count, 8'(wr_cnt - wr0)}), 64'({2'b10, 8'd1, 8'd1}));
        check("post_rst_word", 64'(last_data), 64'h12345678);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter width, default 32: instruction word width; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 128: maximum words the instruction memory holds.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 byte_valid  input  1  a byte is offered on byte_data.
REQ-007 byte_data  input  8  byte stream payload.
REQ-008 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-009 mem_clr  output  1  one-cycle pulse that clears the memory's write counter; drives the memory rst.
REQ-010 mem_write  output  1  one-cycle write strobe to the instruction memory.
REQ-011 mem_data  output  width  assembled word; valid while mem_write is high.
REQ-012 word_count  output  8  words written in the current session.
REQ-013 busy, done, error  output  1 each  session status flags.

Function
REQ-014 A byte SHALL be accepted only on a cycle where byte_valid and byte_ready are both high.
REQ-015 States SHALL be IDLE, LEN, DATA, WRITE, CSUM, DONE, and ERR.
REQ-016 IDLE: start SHALL pulse mem_clr for one cycle, clear word_count, done, and error, and move to LEN.
REQ-017 LEN: the first accepted byte SHALL be the word count N; N=0 or N>DEPTH SHALL move to ERR, otherwise to DATA.
REQ-018 DATA: bytes SHALL pack little-endian; the first byte SHALL go to bits [7:0], and after width/8 bytes the state SHALL move to WRITE.
REQ-019 WRITE: mem_write SHALL be high for exactly one cycle with mem_data stable; byte_ready SHALL be low.
REQ-020 WRITE: word_count SHALL increment by one.
REQ-021 After WRITE: if word_count equals N, the state SHALL move to CSUM when the checksum is enabled, else to DONE; otherwise it SHALL return to DATA.
REQ-022 Latency: mem_write SHALL assert the cycle after the last byte of a word is accepted.
REQ-023 byte_ready SHALL be high only in LEN, DATA, and CSUM.
REQ-024 busy SHALL be high in LEN, DATA, WRITE, and CSUM.
REQ-025 start asserted while busy SHALL be ignored.
REQ-026 DONE and ERR: the done or error flag SHALL be held high until the next start; start in either state SHALL behave as in IDLE.
REQ-027 mem_write SHALL never assert more than N times per session, and never outside WRITE.
REQ-028 A byte_valid gap mid-word SHALL preserve the partial word and byte index indefinitely.

Reset
REQ-029 On rst, the state SHALL go to IDLE.
REQ-030 On rst, byte_ready, mem_clr, mem_write, busy, done, and error SHALL be 0.
REQ-031 On rst, mem_data and word_count SHALL be 0, and the byte index and the checksum accumulator SHALL be cleared.
REQ-032 Reset mid-session SHALL abort the session with no further mem_write, and SHALL NOT pulse mem_clr.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN SHALL select the checksum feature.
REQ-034 With LOADER_CHECKSUM_EN defined: an XOR accumulator SHALL cover every data byte, excluding the length byte.
REQ-035 With LOADER_CHECKSUM_EN defined: after the Nth WRITE, CSUM SHALL accept one byte; equal to the accumulator SHALL move to DONE, unequal SHALL move to ERR.
REQ-036 Without LOADER_CHECKSUM_EN: the CSUM state and the accumulator SHALL be absent, and the Nth WRITE SHALL move directly to DONE.

Verification
REQ-037 start; bytes 02, 13,00,00,00, 93,00,10,00 -> mem_clr one pulse; mem_write twice, with mem_data 0x00000013 then 0x00100093; done=1; word_count=2.
REQ-038 Same stream with LOADER_CHECKSUM_EN and checksum byte 0x90 -> done=1; with checksum byte 0x91 -> error=1, done=0.
REQ-039 Length byte 00, and separately length byte 0x81 with DEPTH=128 -> error=1; no mem_write.
REQ-040 N=1; byte_valid deasserted for 5 cycles between bytes 2 and 3; start pulsed while busy -> one mem_write with the correct word; no restart; no mem_clr.
REQ-041 N=3; rst asserted asynchronously after word 1 -> outputs zero immediately; no further mem_write; a new session afterwards completes normally.
REQ-042 Bytes offered while in IDLE, DONE, or ERR -> byte_ready=0 and no state change.
